// File: rtl/pkt_len_hdr_ins.sv
// Store-and-forward length-header inserter: buffers each sop/eop packet, counts it,
// then replays it behind an HDR_N-word big-endian length header.
module pkt_len_hdr_ins #(
    parameter int DW      = 8,
    parameter int LEN_W   = 16,
    parameter int DAW     = 8,
    parameter int MAW     = 4,
    parameter int MAX_LEN = 1500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop,
    input  logic          dout_rdy,
    output logic [15:0]   drop_cnt
);
    localparam int HDR_N = LEN_W / DW;
    localparam int HIW   = (HDR_N > 1) ? $clog2(HDR_N) : 1;
    localparam logic [DAW:0]     PTR_ONE  = 1;
    localparam logic [MAW:0]     LFP_ONE  = 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [HIW-1:0]   HIDX_ONE = 1;
    localparam logic [HIW-1:0]   HIDX_END = HIW'(HDR_N - 1);

    typedef enum logic [1:0] {IN_IDLE, IN_PKT, IN_DISC} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_HDR, OUT_DATA} out_state_t;

    logic [DW-1:0]    r_mem [2**DAW];
    logic [LEN_W-1:0] r_lf_mem [2**MAW];

    in_state_t        r_in_state;
    out_state_t       r_out_state;
    logic [DAW:0]     r_wr_spec;
    logic [DAW:0]     r_wr_commit;
    logic [DAW:0]     r_rd;
    logic [MAW:0]     r_lf_wp;
    logic [MAW:0]     r_lf_rp;
    logic [LEN_W-1:0] r_in_len;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rem;
    logic [HIW-1:0]   r_hidx;
    logic [15:0]      r_drop_cnt;
    logic [DW-1:0]    r_dout;
    logic             r_dout_vld;
    logic             r_dout_sop;
    logic             r_dout_eop;

    logic [DAW:0]     w_base;
    logic             w_base_full;
    logic             w_sop_word;
    logic             w_cont_word;
    logic             w_abort;
    logic             w_over;
    logic             w_sop_full;
    logic             w_write;
    logic             w_commit;
    logic             w_lf_drop;
    logic             w_lf_full;
    logic             w_lf_empty;
    logic             w_lf_pop;
    logic             w_ld;
    logic [1:0]       w_drop_inc;
    logic [16:0]      w_drop_sum;
    logic [LEN_W-1:0] w_len_new;
    logic [LEN_W-1:0] w_lf_head;
    logic [DW-1:0]    w_hdr_word [HDR_N];

    // A sop always restarts from the last committed point, abandoning any open packet.
    assign w_base      = (r_in_state == IN_PKT && !din_sop) ? r_wr_spec : r_wr_commit;
    assign w_base_full = (w_base[DAW] != r_rd[DAW]) && (w_base[DAW-1:0] == r_rd[DAW-1:0]);
    assign w_sop_word  = din_vld & din_sop;
    assign w_cont_word = din_vld & !din_sop & (r_in_state == IN_PKT);
    assign w_abort     = w_sop_word & (r_in_state == IN_PKT);
    assign w_over      = w_cont_word & (w_base_full | (r_in_len == LEN_MAX));
    assign w_sop_full  = w_sop_word & w_base_full;
    assign w_write     = (w_sop_word & !w_base_full) | (w_cont_word & !w_over);
    assign w_commit    = w_write & din_eop & !w_lf_full;
    assign w_lf_drop   = w_write & din_eop & w_lf_full;
    assign w_len_new   = din_sop ? LEN_ONE : r_in_len + LEN_ONE;
    assign w_drop_inc  = {1'b0, w_abort} + {1'b0, w_over} + {1'b0, w_sop_full} + {1'b0, w_lf_drop};
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

    assign w_lf_full  = (r_lf_wp[MAW] != r_lf_rp[MAW]) && (r_lf_wp[MAW-1:0] == r_lf_rp[MAW-1:0]);
    assign w_lf_empty = (r_lf_wp == r_lf_rp);
    assign w_lf_head  = r_lf_mem[r_lf_rp[MAW-1:0]];
    assign w_ld       = !r_dout_vld | dout_rdy;
    // The length entry is released once the last payload word is in the output register.
    assign w_lf_pop   = (r_out_state == OUT_DATA) & w_ld & (r_rem == LEN_ONE);

    for (genvar gi = 0; gi < HDR_N; gi++) begin : g_hdr
        assign w_hdr_word[gi] = r_len[LEN_W-1-gi*DW -: DW];
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[w_base[DAW-1:0]] <= din;
        if (w_commit) r_lf_mem[r_lf_wp[MAW-1:0]] <= w_len_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lf_wp <= '0;
            r_lf_rp <= '0;
        end else begin
            if (w_commit) r_lf_wp <= r_lf_wp + LFP_ONE;
            if (w_lf_pop) r_lf_rp <= r_lf_rp + LFP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= IN_IDLE;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_in_len    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_commit) begin
                r_wr_spec   <= w_base + PTR_ONE;
                r_wr_commit <= w_base + PTR_ONE;
            end else if (w_write && !din_eop) begin
                r_wr_spec <= w_base + PTR_ONE;
            end else if (w_drop_inc != 2'd0) begin
                r_wr_spec <= r_wr_commit;
            end
            if (w_write) r_in_len <= w_len_new;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (din_vld) begin
                if (din_sop)
                    r_in_state <= din_eop ? IN_IDLE : (w_base_full ? IN_DISC : IN_PKT);
                else if (r_in_state == IN_PKT)
                    r_in_state <= din_eop ? IN_IDLE : (w_over ? IN_DISC : IN_PKT);
                else if (r_in_state == IN_DISC && din_eop)
                    r_in_state <= IN_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= OUT_IDLE;
            r_rd        <= '0;
            r_len       <= '0;
            r_rem       <= '0;
            r_hidx      <= '0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_dout_sop  <= 1'b0;
            r_dout_eop  <= 1'b0;
        end else begin
            if (w_ld) begin
                r_dout_vld <= 1'b0;
                r_dout_sop <= 1'b0;
                r_dout_eop <= 1'b0;
            end
            case (r_out_state)
                OUT_IDLE: begin
                    if (!w_lf_empty) begin
                        r_len       <= w_lf_head;
                        r_hidx      <= '0;
                        r_out_state <= OUT_HDR;
                    end
                end
                OUT_HDR: begin
                    if (w_ld) begin
                        r_dout     <= w_hdr_word[r_hidx];
                        r_dout_vld <= 1'b1;
                        r_dout_sop <= (r_hidx == '0);
                        if (r_hidx == HIDX_END) begin
                            r_rem       <= r_len;
                            r_out_state <= OUT_DATA;
                        end else begin
                            r_hidx <= r_hidx + HIDX_ONE;
                        end
                    end
                end
                OUT_DATA: begin
                    if (w_ld) begin
                        r_dout     <= r_mem[r_rd[DAW-1:0]];
                        r_dout_vld <= 1'b1;
                        r_dout_eop <= (r_rem == LEN_ONE);
                        r_rd       <= r_rd + PTR_ONE;
                        r_rem      <= r_rem - LEN_ONE;
                        if (r_rem == LEN_ONE) r_out_state <= OUT_IDLE;
                    end
                end
                default: r_out_state <= OUT_IDLE;
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign dout_sop = r_dout_sop;
    assign dout_eop = r_dout_eop;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_pkt_len_hdr_ins.sv
// Randomised scoreboard bench for pkt_len_hdr_ins: packets go in, the expected
// header+payload stream is queued, and a monitor checks every output transfer.
module tb_pkt_len_hdr_ins;
    localparam int DW = 8, LEN_W = 16, DAW = 11, MAW = 4, MAX_LEN = 1500;
    localparam int HDR_N = LEN_W / DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_vld, dout_sop, dout_eop;
    logic          dout_rdy = 1'b0;
    logic [15:0]   drop_cnt;

    pkt_len_hdr_ins #(.DW(DW), .LEN_W(LEN_W), .DAW(DAW), .MAW(MAW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_rdy(dout_rdy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } word_t;

    word_t sb[$];
    int compared = 0, mismatched = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int n_pushed = 0, n_eop_seen = 0, exp_drop = 0;
    bit probe_arm = 1'b0;
    int probe_sop_cyc = -1;
    bit gap_check = 1'b0;
    int last_eop_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // dout_rdy policy: 0 = always ready, 1 = random, 2 = held off
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       dout_rdy = 1'b1;
            1:       dout_rdy = 1'($urandom_range(0, 1));
            default: dout_rdy = 1'b0;
        endcase
    end

    // Monitor: checks every transfer against the queue, and that a stalled word holds.
    initial begin
        word_t exp_w;
        word_t prev_w;
        word_t cur_w;
        bit    prev_stall;
        int    widx;
        prev_stall = 1'b0;
        prev_w     = '0;
        widx       = 0;
        forever begin
            @(negedge clk);
            cur_w = {dout, dout_sop, dout_eop};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    compared++;
                    if (!dout_vld || cur_w !== prev_w) begin
                        mismatched++;
                        $display("FAIL stall_hold: got vld=%0b word=%03h, required vld=1 word=%03h",
                                 dout_vld, cur_w, prev_w);
                    end
                end
                prev_stall = dout_vld && !dout_rdy;
                prev_w     = cur_w;
                if (probe_arm && dout_vld && dout_sop) begin
                    probe_sop_cyc = cyc;
                    probe_arm     = 1'b0;
                end
                if (dout_vld && dout_rdy) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_word: got data=%02h sop=%0b eop=%0b, required no output",
                                 dout, dout_sop, dout_eop);
                    end else begin
                        exp_w = sb.pop_front();
                        if (cur_w !== exp_w) begin
                            mismatched++;
                            $display("FAIL word%0d: got data=%02h sop=%0b eop=%0b, required data=%02h sop=%0b eop=%0b",
                                     widx, dout, dout_sop, dout_eop, exp_w.d, exp_w.s, exp_w.e);
                        end
                    end
                    widx++;
                    if (dout_sop && gap_check && last_eop_cyc >= 0) begin
                        compared++;
                        if (cyc - last_eop_cyc != 2) begin
                            mismatched++;
                            $display("FAIL bubble: got %0d cycles eop->sop, required 2", cyc - last_eop_cyc);
                        end
                    end
                    if (dout_eop) begin
                        last_eop_cyc = cyc;
                        n_eop_seen++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [DW-1:0] d, input logic s, input logic e);
        din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
        tick();
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    // Reference model: a packet survives only if it is closed by eop, fits MAX_LEN and
    // the length FIFO had room; survivors appear as big-endian length words then payload.
    task automatic send_pkt(input int len, input bit complete, input int base,
                            input bit lf_full, input bit gaps);
        word_t            pl[$];
        logic [DW-1:0]    d;
        logic [LEN_W-1:0] l;
        logic             e;
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            d = (base >= 0) ? DW'(base + i) : DW'($urandom);
            e = complete && (i == len - 1);
            drive_word(d, i == 0, e);
            pl.push_back({d, 1'b0, e});
        end
        if (complete && len <= MAX_LEN && !lf_full) begin
            l = LEN_W'(len);
            for (int h = 0; h < HDR_N; h++)
                sb.push_back({DW'(l >> (LEN_W - DW * (h + 1))), h == 0, 1'b0});
            foreach (pl[i]) sb.push_back(pl[i]);
            n_pushed++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || dout_vld) && n < 20000) begin
            tick();
            n++;
        end
        compared++;
        if (sb.size() != 0 || n >= 20000) begin
            mismatched++;
            $display("FAIL drain_%s: got %0d words pending after %0d cycles, required 0", tag, sb.size(), n);
        end
    endtask

    task automatic wait_room();
        int n = 0;
        while (n_pushed - n_eop_seen >= 8 && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            compared++;
            mismatched++;
            $display("FAIL room: got %0d packets outstanding, required < 8", n_pushed - n_eop_seen);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int req);
        compared++;
        if (got != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", tag, got, req);
        end
    endtask

    initial begin
        int eop_cyc;
        int n;
        rdy_mode = 0;
        repeat (3) tick();
        check_val("reset_dout", int'(dout), 0);
        check_val("reset_vld", int'(dout_vld), 0);
        check_val("reset_sop", int'(dout_sop), 0);
        check_val("reset_eop", int'(dout_eop), 0);
        check_val("reset_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        tick();

        // 5-word packet and its store-and-forward latency
        probe_sop_cyc = -1;
        probe_arm     = 1'b1;
        send_pkt(5, 1'b1, 'h11, 1'b0, 1'b0);
        eop_cyc = cyc;
        n = 0;
        while (probe_sop_cyc < 0 && n < 50) begin
            tick();
            n++;
        end
        check_val("sop_latency", probe_sop_cyc - eop_cyc, 2);
        wait_drain("five");

        send_pkt(1, 1'b1, 'hAA, 1'b0, 1'b0);
        wait_drain("single");

        // two committed packets released together: one bubble between them
        rdy_mode = 2;
        tick();
        send_pkt(3, 1'b1, 'h20, 1'b0, 1'b0);
        send_pkt(4, 1'b1, 'h30, 1'b0, 1'b0);
        repeat (3) tick();
        last_eop_cyc = -1;
        gap_check    = 1'b1;
        rdy_mode     = 0;
        wait_drain("b2b");
        gap_check = 1'b0;

        // random backpressure, random gaps, stray non-sop words between packets
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            wait_room();
            send_pkt($urandom_range(1, 20), 1'b1, -1, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) drive_word(DW'($urandom), 1'b0, 1'b0);
        end
        wait_drain("random");
        check_val("drop_random", int'(drop_cnt), exp_drop);

        // interrupted packet, MAX_LEN boundary on both sides
        rdy_mode = 0;
        send_pkt(4, 1'b1, -1, 1'b0, 1'b0);
        send_pkt(2, 1'b0, -1, 1'b0, 1'b0);
        send_pkt(6, 1'b1, -1, 1'b0, 1'b0);
        wait_drain("sop_abort");
        check_val("drop_abort", int'(drop_cnt), exp_drop);
        send_pkt(MAX_LEN, 1'b1, -1, 1'b0, 1'b0);
        wait_drain("maxlen");
        send_pkt(MAX_LEN + 1, 1'b1, -1, 1'b0, 1'b0);
        send_pkt(3, 1'b1, -1, 1'b0, 1'b0);
        wait_drain("overlen");
        check_val("drop_overlen", int'(drop_cnt), exp_drop);

        // length FIFO full: 16 held packets, the 17th is dropped
        rdy_mode = 2;
        repeat (2) tick();
        for (int p = 0; p < 16; p++) send_pkt($urandom_range(1, 6), 1'b1, -1, 1'b0, 1'b1);
        send_pkt(5, 1'b1, -1, 1'b1, 1'b0);
        repeat (4) tick();
        check_val("drop_lf_full", int'(drop_cnt), exp_drop);
        rdy_mode = 0;
        wait_drain("lf_full");

        // reset in the middle of output
        send_pkt(20, 1'b1, -1, 1'b0, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        check_val("rst_dout", int'(dout), 0);
        check_val("rst_vld", int'(dout_vld), 0);
        check_val("rst_sop", int'(dout_sop), 0);
        check_val("rst_eop", int'(dout_eop), 0);
        check_val("rst_drop", int'(drop_cnt), 0);
        sb.delete();
        n_pushed = n_eop_seen;
        exp_drop = 0;
        rst = 1'b0;
        tick();
        send_pkt(7, 1'b1, -1, 1'b0, 1'b0);
        wait_drain("post_rst");
        check_val("drop_post_rst", int'(drop_cnt), exp_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
